reader_profile_store: RTL
=========================

Name: reader_profile_store

Overview:
- Serial profile loader and sequencer for the DDS boards.
- Takes Rabbit serial frames (SCLK_PE_3/SDIO_PE_5), synchronises them into the ten_MHz_ext domain and assembles WORD_W-bit DDS words.
- Stores up to DEPTH words in a profile table, then steps through them on sweep-advance pulses.
- Sits between the Rabbit interface pins and the DDS write engine. It replaces single-word capture with a parametrised multi-profile table.

Parameters:
- WORD_W, 184, bits per DDS profile word.
- DEPTH, 20, number of profile slots.
- TIMEOUT_CYC, 4096, idle ten_MHz_ext cycles before a partial word is discarded (optional feature only).

Ports:
- ten_MHz_ext  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- SCLK_PE_3  in  1  Rabbit serial clock, asynchronous, at most ten_MHz_ext/4.
- SDIO_PE_5  in  1  Rabbit serial data, sampled on SCLK rising edge.
- load_en  in  1  high = loading window (the init_key_flag role, inverted sense).
- loop_en  in  1  1 = wrap at end of table, 0 = stop at last word.
- sweep_advance  in  1  single-cycle pulse: step to the next profile.
- profile_out  out  WORD_W  current profile word; first serial bit is at index WORD_W-1.
- profile_valid  out  1  profile_out holds a stored word.
- sweep_count  out  $clog2(DEPTH)  current read index.
- sweep_total  out  $clog2(DEPTH+1)  number of words stored.
- sweep_done  out  1  last word reached with loop_en=0 (sticky).
- overflow  out  1  more than DEPTH words received in this load window (sticky).

Behaviour:
- Reset values: every output is 0, state=IDLE, all pointers are 0. Table contents are undefined.
- Input sync:
  - SCLK and SDIO each pass through a 2-FF synchroniser; SDIO gets one extra stage so it aligns with SCLK.
  - An SCLK rising edge is detected one cycle after the synchronised 0->1 transition.
  - Total latency from pin to shift is 3 clock cycles.
- Shift:
  - On each detected edge in LOADING, shift_reg <= {shift_reg[WORD_W-2:0], sdio_s} and bit_cnt++.
  - When bit_cnt reaches WORD_W-1 on an edge:
    - if wr_ptr<DEPTH, write the word to mem[wr_ptr], increment wr_ptr and sweep_total;
    - otherwise set overflow and drop the word.
    - In both cases bit_cnt is cleared.
- FSM:
  - IDLE: on a load_en rising edge, clear wr_ptr, bit_cnt, sweep_total, overflow and sweep_done, then go to LOADING.
  - LOADING: on load_en falling, discard any partial word (bit_cnt cleared). Go to PLAY if sweep_total>0, else IDLE.
  - PLAY: rd_ptr=0 on entry; profile_valid=1 from the cycle after entry; profile_out=mem[rd_ptr], registered, 1-cycle latency.
    - On sweep_advance with rd_ptr<sweep_total-1: rd_ptr++.
    - On sweep_advance with rd_ptr==sweep_total-1: if loop_en, rd_ptr=0; else hold and set sweep_done.
    - On load_en rising: go to LOADING; profile_valid drops the next cycle.
  - DONE is not a separate state; sweep_done is a sticky flag within PLAY.
- Simultaneous events:
  - load_en rising together with sweep_advance: the load wins and the advance is ignored.
  - SCLK edges outside LOADING are ignored.
  - sweep_advance outside PLAY is ignored.
- Reset asserted mid-frame or mid-play: immediate return to reset values; the table is not cleared.
- sweep_count mirrors rd_ptr. sweep_total saturates at DEPTH.

Optional Feature:
- Macro: READER_TIMEOUT_EN.
- Defined: an idle counter runs in LOADING.
  - It clears on every SCLK edge.
  - When it reaches TIMEOUT_CYC with bit_cnt!=0, bit_cnt is cleared and the partial word is discarded.
  - The counter saturates and has no other effect.
- Undefined: no counter. A partial word persists until load_en falls.

Decomposition:
- Package reader_pkg:
  - state enum {IDLE, LOADING, PLAY};
  - default WORD_W/DEPTH constants;
  - helper localparams for pointer and count widths.
- Sub-module serial_edge_sync: 2-FF synchroniser plus rising-edge detect for SCLK, with aligned delayed SDIO.
- The table is an inferred register array (DEPTH x WORD_W) in the top module.

Test Plan:
- Reset, then 3 words of WORD_W=184 sent (0xA5.. pattern, all-ones, alternating 10) with load_en high, then load_en dropped -> sweep_total=3, profile_valid=1, profile_out=word0.
- In PLAY with loop_en=0, 3 sweep_advance pulses -> sweep_count 1,2,2; sweep_done=1 after the third pulse; profile_out=word2.
- loop_en=1, same table, 3 pulses -> sweep_count 1,2,0; sweep_done stays 0.
- 21 words loaded with DEPTH=20 -> sweep_total=20, overflow=1, mem[19]=word19 (the 21st word is dropped).
- 100 bits sent, then load_en dropped, then 1 full word sent in a new window -> sweep_total=1, with no bit slip in word0.
- READER_TIMEOUT_EN defined, TIMEOUT_CYC=64: 50 bits, 70 idle cycles, then a full word -> the stored word equals the sent word exactly. With the macro undefined, the same stimulus stores a corrupted word.

Source files
------------

// File: rtl/reader_pkg.sv
// -----------------------------------------------------------------------------
// reader_pkg
// Shared types and default sizing for the Rabbit serial profile loader.
//   state_t          : sequencer states (IDLE, LOADING, PLAY)
//   WORD_W_DEF       : bits per DDS profile word
//   DEPTH_DEF        : number of profile slots
//   TIMEOUT_CYC_DEF  : idle cycles before a partial word is dropped
//   PTR_W_DEF        : width of a table index
//   CNT_W_DEF        : width of a word count (0..DEPTH)
// -----------------------------------------------------------------------------
package reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    PLAY    = 2'd2
  } state_t;

  localparam int WORD_W_DEF      = 184;
  localparam int DEPTH_DEF       = 20;
  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int PTR_W_DEF       = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF       = $clog2(DEPTH_DEF + 1);

endpackage

// File: rtl/serial_edge_sync.sv
// -----------------------------------------------------------------------------
// serial_edge_sync
// Brings the asynchronous Rabbit SCLK/SDIO pins into the system clock domain.
// SCLK gets a 2-FF synchroniser plus a registered rising-edge detector; SDIO
// gets a 2-FF synchroniser plus one extra stage so that sdio_bit holds the
// value that was on the pin when the matching SCLK edge was sampled.
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   sclk      in  serial clock pin (asynchronous)
//   sdio      in  serial data pin (asynchronous)
//   sclk_rise out one-cycle pulse per SCLK rising edge
//   sdio_bit  out data bit aligned with sclk_rise
// -----------------------------------------------------------------------------
module serial_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic sdio,
  output logic sclk_rise,
  output logic sdio_bit
);

  logic sclk_meta_r;
  logic sclk_sync_r;
  logic sclk_prev_r;
  logic sclk_rise_r;
  logic sdio_meta_r;
  logic sdio_sync_r;
  logic sdio_dly_r;

  // Synchronise both pins and register one pulse per synchronised SCLK 0->1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      sclk_rise_r <= 1'b0;
      sdio_meta_r <= 1'b0;
      sdio_sync_r <= 1'b0;
      sdio_dly_r  <= 1'b0;
    end else begin
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      sclk_rise_r <= sclk_sync_r & ~sclk_prev_r;
      sdio_meta_r <= sdio;
      sdio_sync_r <= sdio_meta_r;
      sdio_dly_r  <= sdio_sync_r;
    end
  end

  assign sclk_rise = sclk_rise_r;
  assign sdio_bit  = sdio_dly_r;

endmodule

// File: rtl/reader_profile_store.sv
// -----------------------------------------------------------------------------
// reader_profile_store
// Serial profile loader and sequencer for the DDS boards. Rabbit serial frames
// are assembled MSB-first into WORD_W-bit words and stored in a DEPTH-slot
// table while load_en is high; after load_en falls the stored words are
// presented one at a time on profile_out, stepping on sweep_advance.
// Optional build macro: READER_TIMEOUT_EN - drop a partial word after
// TIMEOUT_CYC idle cycles in LOADING.
//   ten_MHz_ext   in  system clock
//   reset_n       in  asynchronous active-low reset
//   SCLK_PE_3     in  Rabbit serial clock (asynchronous)
//   SDIO_PE_5     in  Rabbit serial data
//   load_en       in  loading window
//   loop_en       in  wrap at end of table when 1, stop when 0
//   sweep_advance in  step to the next profile
//   profile_out   out current profile word
//   profile_valid out profile_out holds a stored word
//   sweep_count   out current read index
//   sweep_total   out number of stored words
//   sweep_done    out last word reached with loop_en=0 (sticky)
//   overflow      out more than DEPTH words in this window (sticky)
// -----------------------------------------------------------------------------
module reader_profile_store
  import reader_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                         ten_MHz_ext,
  input  logic                         reset_n,
  input  logic                         SCLK_PE_3,
  input  logic                         SDIO_PE_5,
  input  logic                         load_en,
  input  logic                         loop_en,
  input  logic                         sweep_advance,
  output logic [WORD_W-1:0]            profile_out,
  output logic                         profile_valid,
  output logic [$clog2(DEPTH)-1:0]     sweep_count,
  output logic [$clog2(DEPTH+1)-1:0]   sweep_total,
  output logic                         sweep_done,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  state_t              state_r;
  logic                load_d_r;
  logic [WORD_W-2:0]   shift_r;
  logic [BIT_W-1:0]    bit_cnt_r;
  logic [CNT_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    sweep_total_r;
  logic [WORD_W-1:0]   profile_out_r;
  logic                profile_valid_r;
  logic                sweep_done_r;
  logic                overflow_r;
  logic [WORD_W-1:0]   mem_r [DEPTH];

  logic                sclk_rise_s;
  logic                sdio_s;
  logic                load_rise_s;
  logic                load_fall_s;
  logic                at_last_s;
  logic                mem_we_s;
  logic                timeout_s;
  logic [WORD_W-1:0]   word_s;

  serial_edge_sync u_sync (
    .clk       (ten_MHz_ext),
    .rst_n     (reset_n),
    .sclk      (SCLK_PE_3),
    .sdio      (SDIO_PE_5),
    .sclk_rise (sclk_rise_s),
    .sdio_bit  (sdio_s)
  );

  // Decode load_en edges, end-of-table and the table write strobe
  always_comb begin
    load_rise_s = load_en & ~load_d_r;
    load_fall_s = ~load_en & load_d_r;
    word_s      = {shift_r, sdio_s};
    at_last_s   = (CNT_W'(rd_ptr_r) + CNT_W'(1)) >= sweep_total_r;
    if ((state_r == LOADING) && !load_fall_s && sclk_rise_s &&
        (bit_cnt_r == LAST_BIT) && (wr_ptr_r < CNT_W'(DEPTH))) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

`ifdef READER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt_r;

  // Count idle cycles between SCLK edges while loading; saturates
  always_ff @(posedge ten_MHz_ext or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_r <= '0;
    end else if ((state_r != LOADING) || sclk_rise_s) begin
      idle_cnt_r <= '0;
    end else if (idle_cnt_r != IDLE_W'(TIMEOUT_CYC)) begin
      idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
    end
  end

  assign timeout_s = (state_r == LOADING) && (idle_cnt_r == IDLE_W'(TIMEOUT_CYC)) &&
                     (bit_cnt_r != '0);
`else
  assign timeout_s = 1'b0;
`endif

  // Profile table; contents survive reset on purpose
  always_ff @(posedge ten_MHz_ext) begin
    if (mem_we_s) begin
      mem_r[PTR_W'(wr_ptr_r)] <= word_s;
    end
  end

  // Sequencer FSM with shift register, pointers and registered outputs
  always_ff @(posedge ten_MHz_ext or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      load_d_r        <= 1'b0;
      shift_r         <= '0;
      bit_cnt_r       <= '0;
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      sweep_total_r   <= '0;
      profile_out_r   <= '0;
      profile_valid_r <= 1'b0;
      sweep_done_r    <= 1'b0;
      overflow_r      <= 1'b0;
    end else begin
      load_d_r <= load_en;
      // A new load window wins over anything else, including sweep_advance
      if (load_rise_s && (state_r != LOADING)) begin
        state_r         <= LOADING;
        wr_ptr_r        <= '0;
        bit_cnt_r       <= '0;
        sweep_total_r   <= '0;
        overflow_r      <= 1'b0;
        sweep_done_r    <= 1'b0;
        profile_valid_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            profile_valid_r <= 1'b0;
          end
          LOADING: begin
            profile_valid_r <= 1'b0;
            if (load_fall_s) begin
              bit_cnt_r <= '0;
              if (sweep_total_r != '0) begin
                state_r  <= PLAY;
                rd_ptr_r <= '0;
              end else begin
                state_r <= IDLE;
              end
            end else if (sclk_rise_s) begin
              shift_r <= word_s[WORD_W-2:0];
              if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_r <= '0;
                if (wr_ptr_r < CNT_W'(DEPTH)) begin
                  wr_ptr_r      <= wr_ptr_r + CNT_W'(1);
                  sweep_total_r <= sweep_total_r + CNT_W'(1);
                end else begin
                  overflow_r <= 1'b1;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              end
            end else if (timeout_s) begin
              bit_cnt_r <= '0;
            end
          end
          PLAY: begin
            profile_valid_r <= 1'b1;
            profile_out_r   <= mem_r[rd_ptr_r];
            if (sweep_advance) begin
              if (!at_last_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
              end else if (loop_en) begin
                rd_ptr_r <= '0;
              end else begin
                sweep_done_r <= 1'b1;
              end
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign profile_out   = profile_out_r;
  assign profile_valid = profile_valid_r;
  assign sweep_count   = rd_ptr_r;
  assign sweep_total   = sweep_total_r;
  assign sweep_done    = sweep_done_r;
  assign overflow      = overflow_r;

endmodule
